// File: rtl/cordic_pkg.sv
// Shared types and constants for the sequential CORDIC sine/cosine accelerator.
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_ITER,
    ST_NORM,
    ST_DONE
  } state_t;

  localparam int          ATAN_N       = 24;
  localparam logic [31:0] NAN_CANON    = 32'h7FC00000;
  localparam real         K_REAL       = 0.6072529350;
  localparam real         HALF_PI_REAL = 1.5707963;

  // arctan(2^-i) in radians
  function automatic real atan_real(input int i);
    case (i)
      0:       return 0.7853981633974483;
      1:       return 0.4636476090008061;
      2:       return 0.24497866312686414;
      3:       return 0.12435499454676144;
      4:       return 0.06241880999595735;
      5:       return 0.031239833430268277;
      6:       return 0.015623728620476831;
      7:       return 0.007812341060101111;
      8:       return 0.0039062301319669718;
      9:       return 0.0019531225164788188;
      10:      return 0.0009765621895593195;
      11:      return 0.0004882812111948983;
      12:      return 0.00024414062014936177;
      13:      return 0.00012207031189367021;
      14:      return 0.00006103515617420877;
      15:      return 0.000030517578115526096;
      16:      return 0.000015258789061315762;
      17:      return 0.00000762939453110197;
      18:      return 0.000003814697265606496;
      19:      return 0.000001907348632810187;
      20:      return 0.0000009536743164059608;
      21:      return 0.00000047683715820308884;
      22:      return 0.00000023841857910155797;
      23:      return 0.00000011920928955078068;
      default: return 0.0;
    endcase
  endfunction

  // Real value scaled by 2^fw and rounded to nearest integer
  function automatic longint to_fx(input real v, input int fw);
    return longint'(v * (2.0 ** fw));
  endfunction

  function automatic longint atan_fx(input int i, input int fw);
    return to_fx(atan_real(i), fw);
  endfunction

endpackage

// File: rtl/cordic_accel_seq_if.sv
// Start/done custom-instruction handshake between a host and the CORDIC accelerator.
interface cordic_accel_seq_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        mode;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  modport master (
    output clk_en, start, dataa, mode,
    input  busy, done, result, err
  );

  modport slave (
    input  clk_en, start, dataa, mode,
    output busy, done, result, err
  );
endinterface

// File: rtl/cordic_iter_stage.sv
// One combinational rotation-mode CORDIC micro-rotation, reused every ITER cycle.
module cordic_iter_stage
  import cordic_pkg::*;
#(
  parameter int DATA_W = 26,
  parameter int FRAC_W = 24,
  parameter int CNT_W  = 4
) (
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [DATA_W-1:0] z_in,
  input  logic        [CNT_W-1:0]  i,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic signed [DATA_W-1:0] z_out
);

  localparam int TW = $clog2(ATAN_N);

  logic signed [DATA_W-1:0] atan_tab [ATAN_N];

  for (genvar g = 0; g < ATAN_N; g++) begin : g_atan
    localparam logic signed [DATA_W-1:0] AT = DATA_W'(atan_fx(g, FRAC_W));
    assign atan_tab[g] = AT;
  end

  logic signed [DATA_W-1:0] x_sh;
  logic signed [DATA_W-1:0] y_sh;
  logic signed [DATA_W-1:0] atan_i;
  logic        [TW-1:0]     tidx;

  // Rotate toward z = 0: direction follows the sign of the residual angle
  always_comb begin
    x_sh   = x_in >>> i;
    y_sh   = y_in >>> i;
    tidx   = TW'(i);
    atan_i = (32'(i) < ATAN_N) ? atan_tab[tidx] : '0;
    if (z_in >= 0) begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - atan_i;
    end else begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan_i;
    end
  end

endmodule

// File: rtl/cordic_accel_seq.sv
// Sequential CORDIC sin/cos accelerator: float in, ITERS shared-stage iterations, float out.
module cordic_accel_seq
  import cordic_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int FRAC  = 22,
  parameter int ITERS = 16,
  parameter int GUARD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cordic_accel_seq_if.slave  bus
);

  localparam int IW = WIDTH + GUARD;
  localparam int FW = FRAC + GUARD;
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic signed [IW-1:0] K_FX   = IW'(to_fx(K_REAL, FW));
  localparam logic        [IW-1:0] HP_LIM = IW'(to_fx(HALF_PI_REAL, FRAC) << GUARD);

  typedef struct packed {
    logic                 rej;
    logic signed [IW-1:0] z;
  } conv_t;

  // Float operand to signed fixed point with FW fractional bits, truncated toward zero
  function automatic conv_t float_to_fx(input logic [31:0] f);
    conv_t       r;
    logic [7:0]  e;
    logic [23:0] m;
    logic [IW-1:0] mag;
    int          sh;
    r.rej = 1'b0;
    r.z   = '0;
    e     = f[30:23];
    m     = {1'b1, f[22:0]};
    mag   = '0;
    if (e >= 8'd128) begin
      r.rej = 1'b1;
    end else if (e != 8'd0 && int'(e) >= 127 - FRAC - 1) begin
      sh = int'(e) - 127 + FW - 23;
      if (sh >= 0) mag = IW'(m) << sh;
      else         mag = IW'(m >> (-sh));
      if (mag > HP_LIM) r.rej = 1'b1;
      r.z = f[31] ? -$signed(mag) : $signed(mag);
    end
    return r;
  endfunction

  // Fixed-point result to float: guard bits dropped, mantissa truncated, zero maps to +0.0
  function automatic logic [31:0] fx_to_float(input logic signed [IW-1:0] v);
    logic signed [WIDTH-1:0] vt;
    logic        [WIDTH-1:0] mag;
    logic        [7:0]       ex;
    logic        [22:0]      mt;
    int                      p;
    vt  = WIDTH'(v >>> GUARD);
    mag = $unsigned(vt[WIDTH-1] ? -vt : vt);
    p   = -1;
    for (int b = 0; b < WIDTH; b++) begin
      if (mag[b]) p = b;
    end
    if (p < 0) return 32'h0;
    ex = 8'(127 + p - FRAC);
    mt = 23'({mag, 23'b0} >> p);
    return {vt[WIDTH-1], ex, mt};
  endfunction

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [31:0]          a_p0;
  logic                 mode_p0;
  logic signed [IW-1:0] x_p1;
  logic signed [IW-1:0] y_p1;
  logic signed [IW-1:0] z_p1;
  logic                 rej_p1;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [31:0]          result_q;

  conv_t                conv;
  logic signed [IW-1:0] x_nx;
  logic signed [IW-1:0] y_nx;
  logic signed [IW-1:0] z_nx;
  logic [31:0]          res_fl;

  // Operand conversion and result packing for the CONV and NORM states
  always_comb begin
    conv   = float_to_fx(a_p0);
    res_fl = fx_to_float(mode_p0 ? y_p1 : x_p1);
  end

  cordic_iter_stage #(
    .DATA_W (IW),
    .FRAC_W (FW),
    .CNT_W  (CW)
  ) u_stage (
    .x_in  (x_p1),
    .y_in  (y_p1),
    .z_in  (z_p1),
    .i     (cnt),
    .x_out (x_nx),
    .y_out (y_nx),
    .z_out (z_nx)
  );

  // Control FSM and datapath registers; clk_en low freezes everything including done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      a_p0     <= '0;
      mode_p0  <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      z_p1     <= '0;
      rej_p1   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else if (bus.clk_en) begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_p0    <= bus.dataa;
            mode_p0 <= bus.mode;
            busy_q  <= 1'b1;
            state   <= ST_CONV;
          end
        end
        // Stage p0 -> p1: operand converted, vector initialised to (K, 0)
        ST_CONV: begin
          x_p1   <= K_FX;
          y_p1   <= '0;
          z_p1   <= conv.z;
          rej_p1 <= conv.rej;
          cnt    <= '0;
          // Rejected operands skip the iterations but still pack their result in NORM
          state  <= conv.rej ? ST_NORM : ST_ITER;
        end
        ST_ITER: begin
          x_p1 <= x_nx;
          y_p1 <= y_nx;
          z_p1 <= z_nx;
          if (cnt == CW'(ITERS - 1)) state <= ST_NORM;
          else                       cnt   <= cnt + 1'b1;
        end
        // Stage p1 -> output: renormalise to float and raise done
        ST_NORM: begin
          result_q <= rej_p1 ? NAN_CANON : res_fl;
          err_q    <= rej_p1;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_cordic_accel_seq.sv
// Scoreboard bench for cordic_accel_seq: directed operands with hand-computed sin/cos values.
module tb_cordic_accel_seq;

  logic clk = 1'b0;
  logic rst_n;

  cordic_accel_seq_if bus ();

  cordic_accel_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    bit          is_err;
    real         ev;
    int          lat;
    int          s;
  } exp_t;

  localparam real TOL = 1.0 / 16384.0;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ncyc     = 0;
  logic done_d   = 1'b0;

  always #5 clk = ~clk;

  // Free-running cycle count used to time done against the accepting edge
  always @(posedge clk) ncyc <= ncyc + 1;

  function automatic real f2r(input logic [31:0] f);
    real r;
    int  ex;
    ex = int'(f[30:23]);
    if (ex == 0) return 0.0;
    r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
    return f[31] ? -r : r;
  endfunction

  // Monitor: on each new done pulse pop the oldest expectation and compare
  always @(negedge clk) begin
    exp_t e;
    real  got;
    real  d;
    if (rst_n && bus.done && !done_d) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done result=%h err=%b", bus.result, bus.err);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.err !== e.is_err) begin
          failures++;
          $display("FAIL err_flag op=%h got=%b want=%b", e.a, bus.err, e.is_err);
        end
        checks++;
        if (e.is_err) begin
          if (bus.result !== 32'h7FC00000) begin
            failures++;
            $display("FAIL err_result op=%h got=%h want=7fc00000", e.a, bus.result);
          end
        end else begin
          got = f2r(bus.result);
          d   = got - e.ev;
          if (d < 0.0) d = -d;
          if (d > TOL) begin
            failures++;
            $display("FAIL value op=%h got=%h (%f) want=%f", e.a, bus.result, got, e.ev);
          end
        end
        checks++;
        if (ncyc - e.s != e.lat) begin
          failures++;
          $display("FAIL latency op=%h got=%0d want=%0d", e.a, ncyc - e.s, e.lat);
        end
      end
    end
    done_d = bus.done;
  end

  // Issue one operation and wait (bounded) for its done; optional stall and start spam
  task automatic run_op(input logic [31:0] a, input logic m, input real ev, input bit eerr,
                        input int elat, input int stall_at, input bit spam);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    @(negedge clk);
    bus.dataa = a;
    bus.mode  = m;
    bus.start = 1'b1;
    e.a = a; e.is_err = eerr; e.ev = ev; e.lat = elat; e.s = ncyc;
    sb.push_back(e);
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_after_start op=%h got=%b want=1", a, bus.busy);
        end
      end
      if (k == stall_at)     bus.clk_en = 1'b0;
      if (k == stall_at + 5) bus.clk_en = 1'b1;
      if (bus.done) begin
        seen = 1'b1;
      end else if (spam && (k % 2 == 0)) begin
        bus.start = 1'b1;
        bus.dataa = 32'h3F800000;
        bus.mode  = ~m;
      end
    end
    bus.start  = 1'b0;
    bus.clk_en = 1'b1;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout op=%h got=no_done want=done", a);
    end
  endtask

  task automatic chk_zero(input string nm, input logic [31:0] got);
    checks++;
    if (got !== 32'h0) begin
      failures++;
      $display("FAIL %s got=%h want=0", nm, got);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.dataa  = 32'h0;
    bus.mode   = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_busy",   32'(bus.busy));
    chk_zero("reset_done",   32'(bus.done));
    chk_zero("reset_err",    32'(bus.err));
    chk_zero("reset_result", bus.result);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // operand, mode(0=cos,1=sin), expected value, reject, latency, stall cycle, spam
    run_op(32'h00000000, 1'b0, 1.0,                 1'b0, 19, 0, 1'b0);
    run_op(32'h3F000000, 1'b0, 0.8775825618903728,  1'b0, 19, 0, 1'b0);
    run_op(32'hBF000000, 1'b0, 0.8775825618903728,  1'b0, 19, 0, 1'b0);
    run_op(32'h3F000000, 1'b1, 0.479425538604203,   1'b0, 19, 0, 1'b0);
    run_op(32'hBF000000, 1'b1, -0.479425538604203,  1'b0, 19, 0, 1'b0);
    run_op(32'h3F800000, 1'b1, 0.8414709848078965,  1'b0, 19, 0, 1'b0);
    run_op(32'hBF800000, 1'b0, 0.5403023058681398,  1'b0, 19, 0, 1'b0);
    run_op(32'h3FC00000, 1'b0, 0.0707372016677029,  1'b0, 19, 0, 1'b0);
    run_op(32'h3FC00000, 1'b1, 0.9974949866040544,  1'b0, 19, 0, 1'b0);
    run_op(32'h2EDBE6FF, 1'b0, 1.0,                 1'b0, 19, 0, 1'b0);
    run_op(32'h40800000, 1'b0, 0.0,                 1'b1, 3,  0, 1'b0);
    run_op(32'h7FC00000, 1'b1, 0.0,                 1'b1, 3,  0, 1'b0);
    run_op(32'h3FCCCCCD, 1'b0, 0.0,                 1'b1, 3,  0, 1'b0);
    run_op(32'h7F800000, 1'b1, 0.0,                 1'b1, 3,  0, 1'b0);
    // start hammered while busy: only the first operand (cos 0.5) completes
    run_op(32'h3F000000, 1'b0, 0.8775825618903728,  1'b0, 19, 0, 1'b1);
    repeat (25) @(negedge clk);

    // reset during iteration 8: no done, outputs back to zero immediately
    @(negedge clk);
    bus.dataa = 32'h3F800000;
    bus.mode  = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset_busy",   32'(bus.busy));
    chk_zero("midreset_done",   32'(bus.done));
    chk_zero("midreset_err",    32'(bus.err));
    chk_zero("midreset_result", bus.result);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    run_op(32'h3F800000, 1'b1, 0.8414709848078965,  1'b0, 19, 0, 1'b0);
    // clk_en low for 5 cycles mid-iteration stretches latency by exactly 5
    run_op(32'h3F000000, 1'b1, 0.479425538604203,   1'b0, 24, 6, 1'b0);
    repeat (5) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
